// File: rtl/grid_mover.sv
// Cursor on a ROWS x COLS board moved by four active-low buttons, with hold-to-repeat.
// Define GRID_WRAP_EN to wrap at board edges; without it, any step off the board rejects the whole move.
module grid_mover #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int HOLD_CYC   = 16,
  parameter int REPEAT_CYC = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_up,
  input  logic                    i_down,
  input  logic                    i_left,
  input  logic                    i_right,
  input  logic                    i_load,
  input  logic [7:0]              i_load_i,
  input  logic [7:0]              i_load_j,
  output logic [$clog2(ROWS)-1:0] o_pos_i,
  output logic [$clog2(COLS)-1:0] o_pos_j,
  output logic                    o_move_valid,
  output logic                    o_move_invalid,
  output logic [15:0]             o_move_count
);

  localparam int IW   = $clog2(ROWS);
  localparam int JW   = $clog2(COLS);
  localparam int TMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int TW   = $clog2(TMAX);
  localparam logic [IW-1:0] ROW_MAX = IW'(ROWS - 1);
  localparam logic [JW-1:0] COL_MAX = JW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} StateT;

  StateT         r_state;
  StateT         w_stateNext;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timerNext;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_pressedD;
  logic [3:0]    w_pressed;
  logic          w_event;
  logic [IW-1:0] r_posI;
  logic [JW-1:0] r_posJ;
  logic [IW-1:0] w_rowNext;
  logic [JW-1:0] w_colNext;
  logic          w_rowBad;
  logic          w_colBad;
  logic          w_stepUp;
  logic          w_stepDown;
  logic          w_stepLeft;
  logic          w_stepRight;
  logic          w_accept;
  logic          w_reject;
  logic          r_moveValid;
  logic          r_moveInvalid;
  logic [15:0]   r_moveCount;
  logic [IW-1:0] w_loadI;
  logic [JW-1:0] w_loadJ;

  // Synchroniser flops hold raw button levels, so "released" is all ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 4'b1111;
      r_sync2    <= 4'b1111;
      r_pressedD <= 4'b0000;
    end else begin
      r_sync1    <= {i_up, i_down, i_left, i_right};
      r_sync2    <= r_sync1;
      r_pressedD <= w_pressed;
    end
  end

  assign w_pressed = ~r_sync2;

  always_comb begin
    w_stateNext = r_state;
    w_timerNext = r_timer;
    w_event     = 1'b0;
    if (w_pressed == 4'b0000) begin
      w_stateNext = IDLE;
      w_timerNext = '0;
    end else if (w_pressed != r_pressedD) begin
      w_event     = 1'b1;
      w_stateNext = HOLD;
      w_timerNext = '0;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_timer == TW'(HOLD_CYC - 1)) begin
            w_event     = 1'b1;
            w_stateNext = REPEAT;
            w_timerNext = '0;
          end else begin
            w_timerNext = r_timer + TW'(1);
          end
        end
        REPEAT: begin
          if (r_timer == TW'(REPEAT_CYC - 1)) begin
            w_event     = 1'b1;
            w_timerNext = '0;
          end else begin
            w_timerNext = r_timer + TW'(1);
          end
        end
        default: begin
          w_timerNext = '0;
        end
      endcase
    end
  end

  // Opposite buttons on one axis cancel; what remains is at most one step per axis.
  assign w_stepUp    = w_pressed[3] & ~w_pressed[2];
  assign w_stepDown  = w_pressed[2] & ~w_pressed[3];
  assign w_stepLeft  = w_pressed[1] & ~w_pressed[0];
  assign w_stepRight = w_pressed[0] & ~w_pressed[1];

  always_comb begin
    w_rowNext = r_posI;
    w_colNext = r_posJ;
    w_rowBad  = 1'b0;
    w_colBad  = 1'b0;
    if (w_stepUp) begin
      if (r_posI == '0) begin
`ifdef GRID_WRAP_EN
        w_rowNext = ROW_MAX;
`else
        w_rowBad  = 1'b1;
`endif
      end else begin
        w_rowNext = r_posI - IW'(1);
      end
    end else if (w_stepDown) begin
      if (r_posI == ROW_MAX) begin
`ifdef GRID_WRAP_EN
        w_rowNext = '0;
`else
        w_rowBad  = 1'b1;
`endif
      end else begin
        w_rowNext = r_posI + IW'(1);
      end
    end
    if (w_stepLeft) begin
      if (r_posJ == '0) begin
`ifdef GRID_WRAP_EN
        w_colNext = COL_MAX;
`else
        w_colBad  = 1'b1;
`endif
      end else begin
        w_colNext = r_posJ - JW'(1);
      end
    end else if (w_stepRight) begin
      if (r_posJ == COL_MAX) begin
`ifdef GRID_WRAP_EN
        w_colNext = '0;
`else
        w_colBad  = 1'b1;
`endif
      end else begin
        w_colNext = r_posJ + JW'(1);
      end
    end
  end

  assign w_accept = w_event & (w_stepUp | w_stepDown | w_stepLeft | w_stepRight)
                    & ~w_rowBad & ~w_colBad;
  assign w_reject = w_event & ~w_accept;

  assign w_loadI = (i_load_i > 8'(ROWS - 1)) ? ROW_MAX : i_load_i[IW-1:0];
  assign w_loadJ = (i_load_j > 8'(COLS - 1)) ? COL_MAX : i_load_j[JW-1:0];

  // A load takes priority over a coincident move, but the FSM keeps tracking the buttons.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_timer       <= '0;
      r_posI        <= '0;
      r_posJ        <= '0;
      r_moveValid   <= 1'b0;
      r_moveInvalid <= 1'b0;
      r_moveCount   <= '0;
    end else begin
      r_state       <= w_stateNext;
      r_timer       <= w_timerNext;
      r_moveValid   <= 1'b0;
      r_moveInvalid <= 1'b0;
      if (i_load) begin
        r_posI <= w_loadI;
        r_posJ <= w_loadJ;
      end else if (w_accept) begin
        r_posI      <= w_rowNext;
        r_posJ      <= w_colNext;
        r_moveValid <= 1'b1;
        r_moveCount <= r_moveCount + 16'd1;
      end else if (w_reject) begin
        r_moveInvalid <= 1'b1;
      end
    end
  end

  assign o_pos_i        = r_posI;
  assign o_pos_j        = r_posJ;
  assign o_move_valid   = r_moveValid;
  assign o_move_invalid = r_moveInvalid;
  assign o_move_count   = r_moveCount;

endmodule

// File: tb/tb_grid_mover.sv
// Directed bench for grid_mover (8x8 board, hold 16, repeat 8); expectations follow GRID_WRAP_EN.
module tb_grid_mover;

  logic        clk = 1'b0;
  logic        rst;
  logic        up, down, left, right;
  logic        load;
  logic [7:0]  loadI, loadJ;
  logic [2:0]  posI, posJ;
  logic        valid, invalid;
  logic [15:0] count;

  int compared   = 0;
  int mismatched = 0;
  int expCount   = 0;

  grid_mover #(.ROWS(8), .COLS(8), .HOLD_CYC(16), .REPEAT_CYC(8)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_up           (up),
    .i_down         (down),
    .i_left         (left),
    .i_right        (right),
    .i_load         (load),
    .i_load_i       (loadI),
    .i_load_j       (loadJ),
    .o_pos_i        (posI),
    .o_pos_j        (posJ),
    .o_move_valid   (valid),
    .o_move_invalid (invalid),
    .o_move_count   (count)
  );

  always #5 clk = ~clk;

  // The two pulses must never overlap outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      compared++;
      if (valid && invalid) begin
        mismatched++;
        $display("[TB] FAIL pulse_exclusive: valid=%0b invalid=%0b required not both", valid, invalid);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // pressed = {up, down, left, right}, 1 = pressed
  task automatic applyStimulus(input logic [3:0] pressed);
    {up, down, left, right} = ~pressed;
  endtask

  task automatic loadPos(input logic [7:0] li, input logic [7:0] lj);
    load  = 1'b1;
    loadI = li;
    loadJ = lj;
    tick(1);
    load  = 1'b0;
  endtask

  task automatic pressWindow(input logic [3:0] pressed, input int holdCyc, input int windowCyc,
                             output int nValid, output int nInvalid);
    applyStimulus(pressed);
    nValid   = 0;
    nInvalid = 0;
    for (int k = 1; k <= windowCyc; k++) begin
      tick(1);
      if (k == holdCyc) applyStimulus(4'b0000);
      if (valid)   nValid++;
      if (invalid) nInvalid++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    applyStimulus(4'b0000);
    load  = 1'b1;
    loadI = 8'd5;
    loadJ = 8'd5;
    tick(2);
    compared++;
    if (posI !== 3'd0 || posJ !== 3'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_pos: got (%0d,%0d) expected (0,0)", posI, posJ);
    end
    compared++;
    if (valid !== 1'b0 || invalid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_pulses: got v=%0b i=%0b expected 0,0", valid, invalid);
    end
    compared++;
    if (count !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_count: got %0d expected 0", count);
    end
    load = 1'b0;
    rst  = 1'b0;
    tick(1);
  endtask

  task automatic test_single_move;
    applyStimulus(4'b0001);
    tick(1);
    applyStimulus(4'b0000);
    tick(1);
    compared++;
    if (posJ !== 3'd0 || valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL single_early: got j=%0d v=%0b expected j=0 v=0", posJ, valid);
    end
    tick(1);
    expCount++;
    compared++;
    if (posI !== 3'd0 || posJ !== 3'd1 || valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL single_move: got (%0d,%0d) v=%0b expected (0,1) v=1", posI, posJ, valid);
    end
    tick(5);
    compared++;
    if (count !== 16'(expCount)) begin
      mismatched++;
      $display("[TB] FAIL single_count: got %0d expected %0d", count, expCount);
    end
  endtask

  task automatic test_diagonal;
    int nv, ni;
    loadPos(8'd7, 8'd7);
    compared++;
    if (posI !== 3'd7 || posJ !== 3'd7 || valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL diag_load: got (%0d,%0d) v=%0b expected (7,7) v=0", posI, posJ, valid);
    end
    pressWindow(4'b1010, 8, 12, nv, ni);
    expCount++;
    compared++;
    if (posI !== 3'd6 || posJ !== 3'd6) begin
      mismatched++;
      $display("[TB] FAIL diag_pos: got (%0d,%0d) expected (6,6)", posI, posJ);
    end
    compared++;
    if (nv !== 1 || ni !== 0) begin
      mismatched++;
      $display("[TB] FAIL diag_pulses: got v=%0d i=%0d expected v=1 i=0", nv, ni);
    end
  endtask

  task automatic test_edge;
    int nv, ni;
    int expI, expJ, expV, expN;
    loadPos(8'd0, 8'd0);
    pressWindow(4'b1000, 1, 6, nv, ni);
`ifdef GRID_WRAP_EN
    expI = 7; expJ = 0; expV = 1; expN = 0; expCount++;
`else
    expI = 0; expJ = 0; expV = 0; expN = 1;
`endif
    compared++;
    if (posI !== 3'(expI) || posJ !== 3'(expJ) || nv !== expV || ni !== expN) begin
      mismatched++;
      $display("[TB] FAIL edge_up: got (%0d,%0d) v=%0d i=%0d expected (%0d,%0d) v=%0d i=%0d",
               posI, posJ, nv, ni, expI, expJ, expV, expN);
    end
    loadPos(8'd3, 8'd7);
    pressWindow(4'b0001, 1, 6, nv, ni);
`ifdef GRID_WRAP_EN
    expI = 3; expJ = 0; expV = 1; expN = 0; expCount++;
`else
    expI = 3; expJ = 7; expV = 0; expN = 1;
`endif
    compared++;
    if (posI !== 3'(expI) || posJ !== 3'(expJ) || nv !== expV || ni !== expN) begin
      mismatched++;
      $display("[TB] FAIL edge_right: got (%0d,%0d) v=%0d i=%0d expected (%0d,%0d) v=%0d i=%0d",
               posI, posJ, nv, ni, expI, expJ, expV, expN);
    end
    loadPos(8'd0, 8'd3);
    pressWindow(4'b1001, 1, 6, nv, ni);
`ifdef GRID_WRAP_EN
    expI = 7; expJ = 4; expV = 1; expN = 0; expCount++;
`else
    expI = 0; expJ = 3; expV = 0; expN = 1;
`endif
    compared++;
    if (posI !== 3'(expI) || posJ !== 3'(expJ) || nv !== expV || ni !== expN) begin
      mismatched++;
      $display("[TB] FAIL edge_diag: got (%0d,%0d) v=%0d i=%0d expected (%0d,%0d) v=%0d i=%0d",
               posI, posJ, nv, ni, expI, expJ, expV, expN);
    end
    compared++;
    if (count !== 16'(expCount)) begin
      mismatched++;
      $display("[TB] FAIL edge_count: got %0d expected %0d", count, expCount);
    end
  endtask

  task automatic test_repeat;
    int hits[$];
    int expHits[4];
    int actual;
    expHits = '{3, 19, 27, 35};
    loadPos(8'd0, 8'd0);
    applyStimulus(4'b0001);
    for (int k = 1; k <= 50; k++) begin
      tick(1);
      if (k == 40) applyStimulus(4'b0000);
      if (valid) hits.push_back(k);
    end
    compared++;
    if (hits.size() !== 4) begin
      mismatched++;
      $display("[TB] FAIL repeat_total: got %0d pulses expected 4", hits.size());
    end
    for (int i = 0; i < 4; i++) begin
      actual = (i < hits.size()) ? hits[i] : -1;
      compared++;
      if (actual !== expHits[i]) begin
        mismatched++;
        $display("[TB] FAIL repeat_edge%0d: got edge %0d expected edge %0d", i, actual, expHits[i]);
      end
    end
    expCount += 4;
    compared++;
    if (posJ !== 3'd4 || count !== 16'(expCount)) begin
      mismatched++;
      $display("[TB] FAIL repeat_pos: got j=%0d count=%0d expected j=4 count=%0d", posJ, count, expCount);
    end
  endtask

  task automatic test_cancel_and_load;
    int nv, ni;
    loadPos(8'd2, 8'd2);
    pressWindow(4'b1100, 1, 6, nv, ni);
    compared++;
    if (posI !== 3'd2 || posJ !== 3'd2 || nv !== 0 || ni !== 1) begin
      mismatched++;
      $display("[TB] FAIL cancel: got (%0d,%0d) v=%0d i=%0d expected (2,2) v=0 i=1", posI, posJ, nv, ni);
    end
    applyStimulus(4'b0001);
    tick(1);
    applyStimulus(4'b0000);
    tick(1);
    load  = 1'b1;
    loadI = 8'd200;
    loadJ = 8'd3;
    tick(1);
    load  = 1'b0;
    compared++;
    if (posI !== 3'd7 || posJ !== 3'd3 || valid !== 1'b0 || invalid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL load_wins: got (%0d,%0d) v=%0b i=%0b expected (7,3) v=0 i=0",
               posI, posJ, valid, invalid);
    end
    tick(4);
    compared++;
    if (count !== 16'(expCount) || posJ !== 3'd3) begin
      mismatched++;
      $display("[TB] FAIL load_count: got count=%0d j=%0d expected count=%0d j=3", count, posJ, expCount);
    end
  endtask

  task automatic test_reset_in_repeat;
    loadPos(8'd0, 8'd0);
    applyStimulus(4'b0001);
    tick(22);
    compared++;
    if (posJ !== 3'd2) begin
      mismatched++;
      $display("[TB] FAIL pre_reset_pos: got j=%0d expected 2", posJ);
    end
    rst = 1'b1;
    tick(1);
    compared++;
    if (posI !== 3'd0 || posJ !== 3'd0 || valid !== 1'b0 || invalid !== 1'b0 || count !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: got (%0d,%0d) v=%0b i=%0b count=%0d expected (0,0) 0 0 0",
               posI, posJ, valid, invalid, count);
    end
    tick(1);
    rst = 1'b0;
    tick(2);
    compared++;
    if (posJ !== 3'd0 || valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_early: got j=%0d v=%0b expected j=0 v=0", posJ, valid);
    end
    tick(1);
    compared++;
    if (posJ !== 3'd1 || valid !== 1'b1 || count !== 16'd1) begin
      mismatched++;
      $display("[TB] FAIL post_reset_move: got j=%0d v=%0b count=%0d expected j=1 v=1 count=1",
               posJ, valid, count);
    end
    applyStimulus(4'b0000);
    tick(4);
  endtask

  initial begin
    test_reset();
    test_single_move();
    test_diagonal();
    test_edge();
    test_repeat();
    test_cancel_and_load();
    test_reset_in_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/grid_mover.md
GRID_MOVER -- requirements
Module: grid_mover

Interface
REQ-001 Parameter ROWS, default 8, number of board rows (2..256).
REQ-002 Parameter COLS, default 8, number of board columns (2..256).
REQ-003 Parameter HOLD_CYC, default 16, cycles a press is held before auto-repeat starts (>=2).
REQ-004 Parameter REPEAT_CYC, default 8, cycles between auto-repeat moves (>=2).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 up, down, left, right  in  1 each  asynchronous buttons, active-low (0 = pressed).
REQ-008 load  in  1  synchronous position load strobe.
REQ-009 load_i, load_j  in  8 each  position to load.
REQ-010 pos_i  out  IW=$clog2(ROWS)  current row; up decrements, down increments.
REQ-011 pos_j  out  JW=$clog2(COLS)  current column; left decrements, right increments.
REQ-012 move_valid  out  1  one-cycle pulse, position changed by a move.
REQ-013 move_invalid  out  1  one-cycle pulse, move attempt rejected.
REQ-014 move_count  out  16  count of accepted moves, wraps 0xFFFF->0.

Function
REQ-015 Each button passes a 2-flop synchroniser; synchronised pressed vector P = {~up,~down,~left,~right} after stage 2, registered again as P_d.
REQ-016 Move event when P != P_d and P != 0; a button going low at edge N updates pos on edge N+2 (pos visible after the 3rd edge).
REQ-017 FSM states IDLE, HOLD, REPEAT; IDLE->HOLD on move event; HOLD->REPEAT after HOLD_CYC cycles with P unchanged; in REPEAT an event fires every REPEAT_CYC cycles; any P change with P != 0 gives an event and re-enters HOLD with timer cleared; P == 0 -> IDLE, no event.
REQ-018 Step: dv = down - up, dh = right - left, each in {-1,0,+1}; opposite buttons cancel on that axis.
REQ-019 Two non-cancelled orthogonal buttons produce a diagonal step (both axes in one cycle).
REQ-020 Event with dv = dh = 0 (e.g. up+down only) -> move_invalid pulse, pos unchanged.
REQ-021 Edge with GRID_WRAP_EN undefined: any axis stepping outside 0..ROWS-1 / 0..COLS-1 rejects the whole move (both axes) -> move_invalid, pos unchanged.
REQ-022 Accepted move -> pos updated, move_valid pulse, move_count += 1, all on the same edge.
REQ-023 load=1: pos_i <= min(load_i, ROWS-1), pos_j <= min(load_j, COLS-1); no pulse, count unchanged.
REQ-024 load and move event on same cycle: load wins, event dropped (no pulse), FSM still advances per REQ-017.
REQ-025 move_valid and move_invalid never asserted together.

Reset
REQ-026 rst=1 at an edge: pos_i=0, pos_j=0, move_valid=0, move_invalid=0, move_count=0, FSM=IDLE, timer=0, all synchroniser and P_d flops = released (P=0); overrides load.
REQ-027 Button held across reset: after rst deasserts it is seen as a new press and produces an event per REQ-016.

Configuration
REQ-028 Macro GRID_WRAP_EN defined: out-of-range steps wrap modulo ROWS/COLS per axis (row 0 up -> ROWS-1, col COLS-1 right -> 0) and are accepted moves; undefined: clamp/reject per REQ-021.

Verification
REQ-029 Reset, pos (0,0); right low 1 cycle-held then released -> pos (0,1) on 3rd edge, one move_valid, move_count=1.
REQ-030 Load (7,7); left+up pressed together -> pos (6,6), single move_valid; ROWS=COLS=8.
REQ-031 Pos (0,0), up pressed, no GRID_WRAP_EN -> move_invalid pulse, pos (0,0); with GRID_WRAP_EN -> pos (7,0), move_valid.
REQ-032 Right held 40 cycles, HOLD_CYC=16, REPEAT_CYC=8 -> moves at press+2, then +16, +24, +32 relative edges; 4 move_valid pulses total.
REQ-033 Up+down pressed -> move_invalid only; load=1 (load_i=200, load_j=3) coincident with a right event -> pos (7,3), no pulse.
REQ-034 rst asserted mid-REPEAT with right held -> outputs per REQ-026; after release of rst a fresh move event occurs.
